// File: rtl/stim_player_if.sv
// Operand/result handshake between stim_player (master) and the adder under test (slave).
interface stim_player_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] a_o;
    logic [WIDTH-1:0] b_o;
    logic             op_valid_o;
    logic             op_ready_i;
    logic [WIDTH-1:0] res_i;
    logic             res_valid_i;

    modport master (
        output a_o, b_o, op_valid_o,
        input  op_ready_i, res_i, res_valid_i
    );

    modport slave (
        input  a_o, b_o, op_valid_o,
        output op_ready_i, res_i, res_valid_i
    );
endinterface

// File: rtl/stim_player.sv
// Streams a preloaded operand table to an adder over valid/ready and checks the
// in-order results against (a + b) mod 2^WIDTH held in a small expected FIFO.
module stim_player #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 1024,
    parameter int EXP_DEPTH = 8,
    localparam int AW       = $clog2(DEPTH),
    localparam int EW       = $clog2(EXP_DEPTH)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             ld_valid_i,
    input  logic [AW-1:0]    ld_addr_i,
    input  logic [WIDTH-1:0] ld_a_i,
    input  logic [WIDTH-1:0] ld_b_i,
    input  logic             start_i,
    input  logic [AW:0]      count_i,
    input  logic             loop_i,
    input  logic             stop_i,
    stim_player_if.master    dut,
    output logic             busy_o,
    output logic             done_o,
    output logic [31:0]      sent_o,
    output logic [15:0]      err_cnt_o,
    output logic [AW-1:0]    first_err_idx_o,
    output logic             err_seen_o,
    output logic             spurious_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [EW:0] FULL = (EW+1)'(EXP_DEPTH);

    state_t            state;
    logic [WIDTH-1:0]  mem_a [DEPTH];
    logic [WIDTH-1:0]  mem_b [DEPTH];
    logic [AW-1:0]     idx;
    logic [AW-1:0]     idx_next;
    logic [AW-1:0]     last_idx;
    logic [AW-1:0]     rd_addr;
    logic              rd_en;
    logic              loop_q;
    logic              stop_pend;
    logic [WIDTH+AW-1:0] fifo [EXP_DEPTH];
    logic [EW-1:0]     wr_ptr;
    logic [EW-1:0]     rd_ptr;
    logic [EW:0]       occ;
    logic [EW:0]       occ_next;
    logic              transfer;
    logic              pop;
    logic              last;
    logic              stop_req;
    logic              mismatch;
    logic [WIDTH-1:0]  sum;
    logic [WIDTH-1:0]  head_sum;
    logic [AW-1:0]     head_idx;

    // The read address looks one transfer ahead so the next pair is already
    // registered on a_o/b_o when the current one is accepted (no bubbles).
    always_comb begin
        transfer = dut.op_valid_o && dut.op_ready_i;
        pop      = dut.res_valid_i && (occ != '0);
        stop_req = stop_i || stop_pend;
        last     = (idx == last_idx);
        idx_next = last ? '0 : idx + AW'(1);
        sum      = dut.a_o + dut.b_o;
        {head_sum, head_idx} = fifo[rd_ptr];
        mismatch = (head_sum != dut.res_i);
        rd_en    = 1'b0;
        rd_addr  = '0;
        if (state == RUN) begin
            rd_en   = 1'b1;
            rd_addr = transfer ? idx_next : idx;
        end else if (state == IDLE && start_i && count_i != '0) begin
            rd_en = 1'b1;
        end
        occ_next = occ;
        if (transfer && !pop) begin
            occ_next = occ + (EW+1)'(1);
        end else if (!transfer && pop) begin
            occ_next = occ - (EW+1)'(1);
        end
    end

    // Table contents deliberately survive reset so a run can be replayed.
    always_ff @(posedge clk_i) begin
        if (!reset_i && ld_valid_i && state == IDLE) begin
            mem_a[ld_addr_i] <= ld_a_i;
            mem_b[ld_addr_i] <= ld_b_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            dut.a_o <= '0;
            dut.b_o <= '0;
        end else if (rd_en) begin
            dut.a_o <= mem_a[rd_addr];
            dut.b_o <= mem_b[rd_addr];
        end
    end

    always_ff @(posedge clk_i) begin
        if (transfer) begin
            fifo[wr_ptr] <= {sum, idx};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state           <= IDLE;
            dut.op_valid_o  <= 1'b0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            sent_o          <= '0;
            err_cnt_o       <= '0;
            first_err_idx_o <= '0;
            err_seen_o      <= 1'b0;
            spurious_o      <= 1'b0;
            idx             <= '0;
            last_idx        <= '0;
            loop_q          <= 1'b0;
            stop_pend       <= 1'b0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            occ             <= '0;
        end else begin
            done_o <= 1'b0;
            occ    <= occ_next;
            if (transfer) begin
                wr_ptr <= wr_ptr + EW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + EW'(1);
            end

            case (state)
                IDLE: begin
                    if (start_i && count_i != '0) begin
                        state           <= RUN;
                        busy_o          <= 1'b1;
                        dut.op_valid_o  <= 1'b1;
                        idx             <= '0;
                        last_idx        <= count_i[AW-1:0] - AW'(1);
                        loop_q          <= loop_i;
                        stop_pend       <= 1'b0;
                        sent_o          <= '0;
                        err_cnt_o       <= '0;
                        first_err_idx_o <= '0;
                        err_seen_o      <= 1'b0;
                        spurious_o      <= 1'b0;
                    end else if (start_i) begin
                        done_o <= 1'b1;
                    end
                end

                RUN: begin
                    if (transfer) begin
                        sent_o <= sent_o + 32'd1;
                        idx    <= idx_next;
                    end
                    // A presented pair is never withdrawn; a stop waits for its transfer.
                    if (transfer && (stop_req || (last && !loop_q))) begin
                        state          <= DRAIN;
                        dut.op_valid_o <= 1'b0;
                        stop_pend      <= 1'b0;
                    end else if (!dut.op_valid_o && stop_req) begin
                        state          <= DRAIN;
                        stop_pend      <= 1'b0;
                    end else begin
                        dut.op_valid_o <= (occ_next < FULL);
                        stop_pend      <= stop_req;
                    end
                end

                DRAIN: begin
                    if (occ == '0) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end

                default: begin
                    state          <= IDLE;
                    busy_o         <= 1'b0;
                    dut.op_valid_o <= 1'b0;
                end
            endcase

            // Written after the start clear so a result in the start cycle still registers.
            if (dut.res_valid_i) begin
                if (occ == '0) begin
                    spurious_o <= 1'b1;
                end else if (mismatch) begin
                    if (err_cnt_o != 16'hFFFF) begin
                        err_cnt_o <= err_cnt_o + 16'd1;
                    end
                    err_seen_o <= 1'b1;
                    if (!err_seen_o) begin
                        first_err_idx_o <= head_idx;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_stim_player.sv
// Directed bench for stim_player: a vector table of one-shot runs plus hand-written
// sequences for loop/stop, FIFO backpressure, ready stalls and mid-run reset.
module tb_stim_player;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    typedef struct {
        logic [AW:0]   count;
        logic [15:0]   corrupt;
        logic [31:0]   exp_sent;
        logic [15:0]   exp_err;
        logic [AW-1:0] exp_first;
        logic          exp_seen;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ld_valid = 1'b0;
    logic [AW-1:0]    ld_addr = '0;
    logic [WIDTH-1:0] ld_a = '0;
    logic [WIDTH-1:0] ld_b = '0;
    logic             start = 1'b0;
    logic [AW:0]      count = '0;
    logic             loop = 1'b0;
    logic             stop = 1'b0;
    logic             busy;
    logic             done;
    logic [31:0]      sent;
    logic [15:0]      err_cnt;
    logic [AW-1:0]    first_err_idx;
    logic             err_seen;
    logic             spurious;

    int checks = 0;
    int errors = 0;
    int stall_breaks = 0;
    int ret_total = 0;
    int ret_base = 0;
    int inject_req = 0;
    int inject_ack = 0;
    bit withhold = 1'b0;
    logic [15:0] corrupt_mask = '0;

    logic [WIDTH-1:0] tbl_a [DEPTH];
    logic [WIDTH-1:0] tbl_b [DEPTH];
    logic [WIDTH-1:0] issued_a [$];
    logic [WIDTH-1:0] issued_b [$];
    logic [WIDTH-1:0] pend [$];

    stim_player_if #(.WIDTH(WIDTH)) dif ();

    stim_player #(.WIDTH(WIDTH), .DEPTH(DEPTH), .EXP_DEPTH(8)) u_dut (
        .clk_i           (clk),
        .reset_i         (rst),
        .ld_valid_i      (ld_valid),
        .ld_addr_i       (ld_addr),
        .ld_a_i          (ld_a),
        .ld_b_i          (ld_b),
        .start_i         (start),
        .count_i         (count),
        .loop_i          (loop),
        .stop_i          (stop),
        .dut             (dif),
        .busy_o          (busy),
        .done_o          (done),
        .sent_o          (sent),
        .err_cnt_o       (err_cnt),
        .first_err_idx_o (first_err_idx),
        .err_seen_o      (err_seen),
        .spurious_o      (spurious)
    );

    initial forever #5 clk = ~clk;

    // Registered-adder model: logs every accepted pair and answers one cycle later
    // unless withheld; can corrupt chosen results or send an unsolicited one.
    initial begin
        logic [WIDTH-1:0] r;
        logic [15:0]      cm;
        dif.res_valid_i = 1'b0;
        dif.res_i = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                pend.delete();
            end else if (dif.op_valid_o && dif.op_ready_i) begin
                issued_a.push_back(dif.a_o);
                issued_b.push_back(dif.b_o);
                pend.push_back(dif.a_o + dif.b_o);
            end
            #1;
            dif.res_valid_i = 1'b0;
            dif.res_i = '0;
            if (inject_req != inject_ack) begin
                inject_ack++;
                dif.res_valid_i = 1'b1;
                dif.res_i = 8'h33;
            end else if (!withhold && !rst && pend.size() > 0) begin
                r = pend.pop_front();
                cm = corrupt_mask >> (ret_total - ret_base);
                if (cm[0]) r = r ^ 8'h05;
                dif.res_valid_i = 1'b1;
                dif.res_i = r;
                ret_total++;
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [AW:0] cnt, input logic lp);
        @(negedge clk);
        count = cnt;
        loop = lp;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_table();
        for (int i = 0; i < DEPTH; i++) begin
            case (i)
                0: begin tbl_a[i] = 8'd1;   tbl_b[i] = 8'd2;   end
                1: begin tbl_a[i] = 8'd255; tbl_b[i] = 8'd1;   end
                2: begin tbl_a[i] = 8'd100; tbl_b[i] = 8'd100; end
                3: begin tbl_a[i] = 8'd0;   tbl_b[i] = 8'd0;   end
                default: begin
                    tbl_a[i] = 8'(i * 13 + 7);
                    tbl_b[i] = 8'(i * 29);
                end
            endcase
            ld_valid = 1'b1;
            ld_addr = AW'(i);
            ld_a = tbl_a[i];
            ld_b = tbl_b[i];
            @(negedge clk);
        end
        ld_valid = 1'b0;
    endtask

    task automatic check_seq(input string name, input int base, input int n, input int cnt);
        int bad = 0;
        check_output({name, "_len"}, 32'(issued_a.size() - base), 32'(n));
        for (int k = 0; k < n; k++) begin
            if (base + k < issued_a.size()) begin
                if (issued_a[base + k] !== tbl_a[k % cnt] || issued_b[base + k] !== tbl_b[k % cnt]) bad++;
            end
        end
        check_output({name, "_bad_entries"}, 32'(bad), 0);
    endtask

    task automatic check_reset(input string name);
        check_output({name, "_op_valid"}, 32'(dif.op_valid_o), 0);
        check_output({name, "_a"}, 32'(dif.a_o), 0);
        check_output({name, "_b"}, 32'(dif.b_o), 0);
        check_output({name, "_busy"}, 32'(busy), 0);
        check_output({name, "_done"}, 32'(done), 0);
        check_output({name, "_sent"}, sent, 0);
        check_output({name, "_err_cnt"}, 32'(err_cnt), 0);
        check_output({name, "_first_idx"}, 32'(first_err_idx), 0);
        check_output({name, "_err_seen"}, 32'(err_seen), 0);
        check_output({name, "_spurious"}, 32'(spurious), 0);
    endtask

    // mode 0: plain, 1: toggle ready every 3 cycles and try a table write, 2: stop after 10 transfers
    task automatic wait_done(input int mode, output int dones, output int ret_at_done);
        logic [WIDTH-1:0] pa = '0;
        logic [WIDTH-1:0] pb = '0;
        bit pstall = 1'b0;
        int done_i = -1;
        dones = 0;
        ret_at_done = -1;
        for (int i = 0; i < 400; i++) begin
            if (pstall && (dif.a_o !== pa || dif.b_o !== pb || dif.op_valid_o !== 1'b1)) stall_breaks++;
            if (done) begin
                dones++;
                if (done_i < 0) begin
                    done_i = i;
                    ret_at_done = ret_total - ret_base;
                end
            end
            if (done_i >= 0 && i >= done_i + 3) break;
            if (mode == 1) begin
                if (i % 3 == 0) dif.op_ready_i = !dif.op_ready_i;
                ld_valid = (i == 4);
                ld_addr = 4'd1;
                ld_a = 8'h09;
                ld_b = 8'h09;
            end
            if (mode == 2) stop = (sent == 32'd9);
            pstall = dif.op_valid_o && !dif.op_ready_i;
            pa = dif.a_o;
            pb = dif.b_o;
            @(negedge clk);
        end
        stop = 1'b0;
        ld_valid = 1'b0;
        dif.op_ready_i = 1'b1;
    endtask

    initial begin
        vec_t vecs [5];
        int dones;
        int ret_done;
        int base;
        bit found;

        vecs[0] = '{5'd4,  16'h0000, 32'd4,  16'd0, 4'd0, 1'b0};
        vecs[1] = '{5'd4,  16'h0002, 32'd4,  16'd1, 4'd1, 1'b1};
        vecs[2] = '{5'd4,  16'h000C, 32'd4,  16'd2, 4'd2, 1'b1};
        vecs[3] = '{5'd1,  16'h0000, 32'd1,  16'd0, 4'd0, 1'b0};
        vecs[4] = '{5'd16, 16'h8010, 32'd16, 16'd2, 4'd4, 1'b1};

        dif.op_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst = 1'b0;
        load_table();

        foreach (vecs[v]) begin
            corrupt_mask = vecs[v].corrupt;
            ret_base = ret_total;
            base = issued_a.size();
            apply_stimulus(vecs[v].count, 1'b0);
            check_output($sformatf("v%0d_first_valid", v), 32'(dif.op_valid_o), 1);
            wait_done(0, dones, ret_done);
            check_output($sformatf("v%0d_done_pulses", v), 32'(dones), 1);
            check_output($sformatf("v%0d_results_before_done", v), 32'(ret_done), 32'(vecs[v].count));
            check_output($sformatf("v%0d_sent", v), sent, vecs[v].exp_sent);
            check_output($sformatf("v%0d_err_cnt", v), 32'(err_cnt), 32'(vecs[v].exp_err));
            check_output($sformatf("v%0d_first_idx", v), 32'(first_err_idx), 32'(vecs[v].exp_first));
            check_output($sformatf("v%0d_err_seen", v), 32'(err_seen), 32'(vecs[v].exp_seen));
            check_output($sformatf("v%0d_busy", v), 32'(busy), 0);
            check_output($sformatf("v%0d_spurious", v), 32'(spurious), 0);
            check_seq($sformatf("v%0d_seq", v), base, int'(vecs[v].count), int'(vecs[v].count));
        end
        corrupt_mask = '0;

        // count of zero: immediate done, no transfers
        base = issued_a.size();
        apply_stimulus(5'd0, 1'b0);
        check_output("cnt0_done", 32'(done), 1);
        check_output("cnt0_busy", 32'(busy), 0);
        @(negedge clk);
        check_output("cnt0_done_cleared", 32'(done), 0);
        check_output("cnt0_no_transfer", 32'(issued_a.size() - base), 0);

        // ready toggling with an ignored table write during the run
        stall_breaks = 0;
        ret_base = ret_total;
        base = issued_a.size();
        apply_stimulus(5'd10, 1'b0);
        wait_done(1, dones, ret_done);
        check_output("stall_stable", 32'(stall_breaks), 0);
        check_output("stall_done_pulses", 32'(dones), 1);
        check_output("stall_sent", sent, 10);
        check_seq("stall_seq", base, 10, 10);

        // loop of 3 stopped after 10 transfers
        ret_base = ret_total;
        base = issued_a.size();
        apply_stimulus(5'd3, 1'b1);
        wait_done(2, dones, ret_done);
        check_output("loop_done_pulses", 32'(dones), 1);
        check_output("loop_results_before_done", 32'(ret_done), 10);
        check_output("loop_sent", sent, 10);
        check_seq("loop_seq", base, 10, 3);

        // FIFO full: 8 outstanding results block issuing
        withhold = 1'b1;
        ret_base = ret_total;
        base = issued_a.size();
        apply_stimulus(5'd12, 1'b0);
        repeat (12) @(negedge clk);
        check_output("full_sent", sent, 8);
        check_output("full_op_valid", 32'(dif.op_valid_o), 0);
        check_output("full_busy", 32'(busy), 1);
        withhold = 1'b0;
        @(negedge clk);
        check_output("full_result_cycle_valid", 32'(dif.op_valid_o), 0);
        @(negedge clk);
        check_output("full_resume_valid", 32'(dif.op_valid_o), 1);
        wait_done(0, dones, ret_done);
        check_output("full_done_pulses", 32'(dones), 1);
        check_output("full_sent_final", sent, 12);
        check_output("full_err_cnt", 32'(err_cnt), 0);
        check_seq("full_seq", base, 12, 12);

        // reset mid-run with 3 results outstanding
        withhold = 1'b1;
        ret_base = ret_total;
        apply_stimulus(5'd12, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (sent == 32'd3) begin
                dif.op_ready_i = 1'b0;
                found = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        check_output("rst_reach3", 32'(found), 1);
        @(negedge clk);
        check_output("rst_pre_busy", 32'(busy), 1);
        check_output("rst_pre_sent", sent, 3);
        rst = 1'b1;
        @(negedge clk);
        check_reset("midrun");
        rst = 1'b0;
        withhold = 1'b0;
        dif.op_ready_i = 1'b1;
        inject_req++;
        repeat (3) @(negedge clk);
        check_output("rst_spurious", 32'(spurious), 1);
        check_output("rst_spurious_no_err", 32'(err_cnt), 0);
        ret_base = ret_total;
        base = issued_a.size();
        apply_stimulus(5'd12, 1'b0);
        check_output("replay_spurious_cleared", 32'(spurious), 0);
        wait_done(0, dones, ret_done);
        check_output("replay_done_pulses", 32'(dones), 1);
        check_seq("replay_seq", base, 12, 12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
